// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: ping-pong frame buffer in front of an Avalon-ST FFT sink.
// One bank fills with samples while the other full bank streams out as a
// sop/eop packet; frames in flight are tracked via the FFT source side.

module fft_frame_sequencer #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned FFT_PTS      = 1024,
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned MAX_INFLIGHT = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              sink_valid,
   input  logic              sink_ready,
   output logic              sink_sop,
   output logic              sink_eop,
   output logic [DATA_W-1:0] sink_real,
   output logic [DATA_W-1:0] sink_imag,
   output logic [10:0]       fftpts_in,
   output logic              inverse,
   input  logic              source_valid,
   input  logic              source_eop,
   output logic [1:0]        inflight,
   output logic              overrun,
   output logic [15:0]       frames_sent
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_PTS - 1);
   localparam logic [1:0]        MAX_IF    = 2'(MAX_INFLIGHT);

   typedef enum logic [1:0] {StIdle, StPrime, StStream} state_t;

   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_mem [2*FFT_PTS];
   logic [DATA_W-1:0]   r_rd_data;
   logic [1:0]          r_full;
   logic                r_wr_bank, r_rd_bank;
   logic [ADDR_W-1:0]   r_wr_ptr, r_rd_addr, r_out_idx;
   logic                r_sink_valid, r_sink_sop, r_sink_eop;
   logic [DATA_W-1:0]   r_sink_real;
   logic [1:0]          r_inflight;
   logic                r_overrun;
   logic [15:0]         r_frames;
   logic                w_wr_en, w_wr_last, w_xfer, w_ret;
   logic                w_rd_en, w_load, w_done;

   // A sample is only accepted into a bank that is not waiting to be drained.
   assign w_wr_en   = sample_valid & ~r_full[r_wr_bank];
   assign w_wr_last = w_wr_en & (r_wr_ptr == LAST_ADDR);
   assign w_xfer    = r_sink_valid & sink_ready;
   assign w_ret     = source_valid & source_eop;

   // Frame RAM: write port owned by the fill side, registered read port by the FSM.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[{r_wr_bank, r_wr_ptr}] <= sample_in;
      if (w_rd_en) r_rd_data <= r_mem[{r_rd_bank, r_rd_addr}];
   end

   // Read FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= StIdle;
      else          r_state <= w_state_nxt;
   end

   // Read FSM next state; in STREAM each transfer refills the output from the
   // prefetched RAM word and issues the read for the word after it.
   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_load      = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (r_full[r_rd_bank] && (r_inflight < MAX_IF)) begin
               w_rd_en     = 1'b1;
               w_state_nxt = StPrime;
            end
         end
         StPrime: begin
            w_rd_en     = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = StStream;
         end
         StStream: begin
            if (w_xfer) begin
               if (r_sink_eop) begin
                  w_done      = 1'b1;
                  w_state_nxt = StIdle;
               end else begin
                  w_rd_en = 1'b1;
                  w_load  = 1'b1;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Fill side: write pointer, bank select and sticky overrun.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_bank <= 1'b0;
         r_wr_ptr  <= '0;
         r_overrun <= 1'b0;
      end else if (sample_valid) begin
         if (r_full[r_wr_bank]) begin
            r_overrun <= 1'b1;
         end else begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_wr_last) r_wr_bank <= ~r_wr_bank;
         end
      end
   end

   // Bank full flags: set by the fill side, cleared once the bank is drained.
   // Set and clear never target the same bank in one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= '0;
      end else begin
         if (w_wr_last) r_full[r_wr_bank] <= 1'b1;
         if (w_done)    r_full[r_rd_bank] <= 1'b0;
      end
   end

   // Read datapath: read address, output word register and sop/eop markers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_bank    <= 1'b0;
         r_rd_addr    <= '0;
         r_out_idx    <= '0;
         r_sink_valid <= 1'b0;
         r_sink_sop   <= 1'b0;
         r_sink_eop   <= 1'b0;
         r_sink_real  <= '0;
      end else begin
         if (w_rd_en) r_rd_addr <= r_rd_addr + ADDR_W'(1);
         if (w_load) begin
            r_sink_valid <= 1'b1;
            r_sink_real  <= r_rd_data;
            if (r_state == StPrime) begin
               r_out_idx  <= '0;
               r_sink_sop <= 1'b1;
               r_sink_eop <= 1'b0;
            end else begin
               r_out_idx  <= r_out_idx + ADDR_W'(1);
               r_sink_sop <= 1'b0;
               r_sink_eop <= (r_out_idx + ADDR_W'(1)) == LAST_ADDR;
            end
         end
         if (w_done) begin
            r_sink_valid <= 1'b0;
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_bank    <= ~r_rd_bank;
         end
      end
   end

   // Frames in flight (saturating at 0) and completed-frame counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_inflight <= '0;
         r_frames   <= '0;
      end else begin
         if (w_done && !w_ret)                           r_inflight <= r_inflight + 2'd1;
         else if (!w_done && w_ret && r_inflight != '0)  r_inflight <= r_inflight - 2'd1;
         if (w_done) r_frames <= r_frames + 16'd1;
      end
   end

   assign sink_valid  = r_sink_valid;
   assign sink_sop    = r_sink_sop;
   assign sink_eop    = r_sink_eop;
   assign sink_real   = r_sink_real;
   assign sink_imag   = '0;
   assign fftpts_in   = 11'(FFT_PTS);
   assign inverse     = 1'b0;
   assign inflight    = r_inflight;
   assign overrun     = r_overrun;
   assign frames_sent = r_frames;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer (FFT_PTS=8): directed scenarios plus a random
// phase, checked every cycle against a frame-queue model of the sequencer.

module tb_fft_frame_sequencer;

   localparam int unsigned DATA_W       = 32;
   localparam int unsigned FFT_PTS      = 8;
   localparam int unsigned ADDR_W       = 3;
   localparam int unsigned MAX_INFLIGHT = 2;

   logic              clk          = 1'b0;
   logic              reset_n      = 1'b0;
   logic [DATA_W-1:0] sample_in    = '0;
   logic              sample_valid = 1'b0;
   logic              sink_ready   = 1'b0;
   logic              source_valid = 1'b0;
   logic              source_eop   = 1'b0;
   logic              sink_valid, sink_sop, sink_eop, inverse, overrun;
   logic [DATA_W-1:0] sink_real, sink_imag;
   logic [10:0]       fftpts_in;
   logic [1:0]        inflight;
   logic [15:0]       frames_sent;

   always #5 clk = ~clk;

   fft_frame_sequencer #(
      .DATA_W       (DATA_W),
      .FFT_PTS      (FFT_PTS),
      .ADDR_W       (ADDR_W),
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sink_valid   (sink_valid),
      .sink_ready   (sink_ready),
      .sink_sop     (sink_sop),
      .sink_eop     (sink_eop),
      .sink_real    (sink_real),
      .sink_imag    (sink_imag),
      .fftpts_in    (fftpts_in),
      .inverse      (inverse),
      .source_valid (source_valid),
      .source_eop   (source_eop),
      .inflight     (inflight),
      .overrun      (overrun),
      .frames_sent  (frames_sent)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: completed frames wait as words in m_words; at most two frames can
   // be full at once (one per bank), and a sample arriving then is dropped.
   logic [DATA_W-1:0] m_cur[$];
   logic [DATA_W-1:0] m_words[$];
   logic [DATA_W-1:0] seen[$];
   int                seen_cyc[$];
   int                m_nfull = 0, m_idx = 0, m_inflight = 0, m_wait = 0;
   logic              m_overrun = 1'b0, m_just_done = 1'b0;
   logic [15:0]       m_sent = '0;
   int                cyc = 0, n_sop = 0, n_eop = 0, nf_s;
   logic              xfer_s, fin_s, ret_s;
   logic [DATA_W-1:0] pop_s;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cur.delete();
         m_words.delete();
         m_nfull     = 0;
         m_idx       = 0;
         m_inflight  = 0;
         m_overrun   = 1'b0;
         m_sent      = '0;
         m_just_done = 1'b0;
      end else begin
         cyc++;
         m_just_done = 1'b0;
         nf_s   = m_nfull;
         xfer_s = sink_valid && sink_ready;
         fin_s  = 1'b0;
         if (xfer_s) begin
            seen.push_back(sink_real);
            seen_cyc.push_back(cyc);
            if (sink_sop) n_sop++;
            if (sink_eop) n_eop++;
            if (m_words.size() > 0) pop_s = m_words.pop_front();
            if (m_idx == FFT_PTS - 1) begin
               m_idx       = 0;
               m_nfull--;
               m_sent++;
               fin_s       = 1'b1;
               m_just_done = 1'b1;
            end else begin
               m_idx++;
            end
         end
         ret_s = source_valid && source_eop;
         if (fin_s && !ret_s)                       m_inflight++;
         else if (!fin_s && ret_s && m_inflight > 0) m_inflight--;
         if (sample_valid) begin
            if (nf_s == 2) begin
               m_overrun = 1'b1;
            end else begin
               m_cur.push_back(sample_in);
               if (m_cur.size() == FFT_PTS) begin
                  while (m_cur.size() > 0) m_words.push_back(m_cur.pop_front());
                  m_nfull++;
               end
            end
         end
      end
   end

   // Compare process: outputs are stable at the falling edge.
   always @(negedge clk) begin
      chk("fftpts_in", 64'(fftpts_in), 64'(FFT_PTS));
      chk("inverse", 64'(inverse), 64'd0);
      chk("sink_imag", 64'(sink_imag), 64'd0);
      chk("inflight", 64'(inflight), 64'(m_inflight));
      chk("overrun", 64'(overrun), 64'(m_overrun));
      chk("frames_sent", 64'(frames_sent), 64'(m_sent));
      if (sink_valid) begin
         if (m_words.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_without_frame: sink_valid=1, required 0 (t=%0t)", $time);
         end else begin
            chk("sink_real", 64'(sink_real), 64'(m_words[0]));
         end
         chk("sink_sop", 64'(sink_sop), 64'(m_idx == 0));
         chk("sink_eop", 64'(sink_eop), 64'(m_idx == FFT_PTS - 1));
         if (m_idx == 0) chk("start_below_max", 64'(m_inflight < MAX_INFLIGHT), 64'd1);
      end
      if (m_just_done) chk("valid_after_eop", 64'(sink_valid), 64'd0);
      // A sendable frame must show sink_valid within 2 cycles of becoming sendable.
      if (reset_n && m_nfull > 0 && m_idx == 0 && m_inflight < MAX_INFLIGHT && !sink_valid) begin
         m_wait++;
         chk("start_latency_bound", 64'(m_wait <= 2), 64'd1);
      end else begin
         m_wait = 0;
      end
   end

   // sink_ready driver: 0 = high, 1 = pattern 1,0,0,1, 2 = low, 3 = random.
   int rmode = 2;
   int rcnt  = 0;
   always @(negedge clk) begin
      case (rmode)
         0:       sink_ready = 1'b1;
         1:       sink_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
         2:       sink_ready = 1'b0;
         default: sink_ready = 1'($urandom % 2);
      endcase
      rcnt++;
   end

   task automatic push(input int v, input int gap);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = DATA_W'(v);
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic burst(input int first, input int n);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         sample_valid = 1'b1;
         sample_in    = DATA_W'(first + i);
         @(negedge clk);
      end
      sample_valid = 1'b0;
   endtask

   task automatic src_pulse();
      @(negedge clk);
      source_valid = 1'b1;
      source_eop   = 1'b1;
      @(negedge clk);
      source_valid = 1'b0;
      source_eop   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n      = 1'b0;
      sample_valid = 1'b0;
      source_valid = 1'b0;
      source_eop   = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      reset_n = 1'b1;
      seen.delete();
      seen_cyc.delete();
      n_sop = 0;
      n_eop = 0;
   endtask

   task automatic chk_seq(input string name, input int base, input int first, input int n);
      for (int i = 0; i < n; i++) begin
         if (base + i < seen.size()) begin
            chk(name, 64'(seen[base + i]), 64'(first + i));
         end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: word %0d missing, got %0d words, required %0d",
                     name, base + i, seen.size(), base + n);
         end
      end
   endtask

   int lat, k;

   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_sink_valid", 64'(sink_valid), 64'd0);
      chk("rst_frames_sent", 64'(frames_sent), 64'd0);
      chk("rst_fftpts_in", 64'(fftpts_in), 64'd8);
      #2 reset_n = 1'b1;

      // One frame, samples spaced 4 cycles apart, sink always ready.
      rmode = 0;
      for (int i = 1; i < 8; i++) push(i, 2);
      push(8, 0);
      lat = 1;
      while (!sink_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      // Full flag set at the 8th-sample edge; IDLE then PRIME then valid.
      chk("first_valid_latency", 64'(lat), 64'd3);
      repeat (20) @(negedge clk);
      chk_seq("t1_data", 0, 1, 8);
      chk("t1_words", 64'(seen.size()), 64'd8);
      if (seen_cyc.size() == 8) chk("t1_back_to_back", 64'(seen_cyc[7] - seen_cyc[0]), 64'd7);
      chk("t1_frames_sent", 64'(frames_sent), 64'd1);
      chk("t1_inflight", 64'(inflight), 64'd1);

      // Same stimulus under ready pattern 1,0,0,1.
      do_reset();
      rmode = 1;
      rcnt  = 0;
      for (int i = 1; i <= 8; i++) push(i, 2);
      repeat (40) @(negedge clk);
      chk_seq("t2_data", 0, 1, 8);
      chk("t2_sop_count", 64'(n_sop), 64'd1);
      chk("t2_eop_count", 64'(n_eop), 64'd1);
      chk("t2_frames_sent", 64'(frames_sent), 64'd1);

      // Overrun: 24 back-to-back samples with the sink stalled.
      do_reset();
      rmode = 2;
      burst(1, 24);
      repeat (5) @(negedge clk);
      chk("t3_overrun", 64'(overrun), 64'd1);
      chk("t3_stalled_valid", 64'(sink_valid), 64'd1);
      chk("t3_stalled_word", 64'(sink_real), 64'd1);
      rmode = 0;
      repeat (30) @(negedge clk);
      chk("t3_words", 64'(seen.size()), 64'd16);
      chk_seq("t3_data", 0, 1, 16);
      chk("t3_frames_sent", 64'(frames_sent), 64'd2);
      chk("t3_inflight", 64'(inflight), 64'd2);

      // Third frame held back by the in-flight limit until a source eop.
      burst(25, 8);
      repeat (15) @(negedge clk);
      chk("t4_held_valid", 64'(sink_valid), 64'd0);
      chk("t4_held_inflight", 64'(inflight), 64'd2);
      src_pulse();
      lat = 1;
      while (!sink_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("t4_release_latency", 64'(lat), 64'd3);
      repeat (20) @(negedge clk);
      chk_seq("t4_data", 16, 25, 8);
      chk("t4_frames_sent", 64'(frames_sent), 64'd3);
      chk("t4_inflight", 64'(inflight), 64'd2);

      // Source eop coinciding with the sink eop transfer leaves inflight alone.
      do_reset();
      rmode = 0;
      for (int i = 1; i <= 8; i++) push(i, 2);
      repeat (20) @(negedge clk);
      chk("t5_inflight_one", 64'(inflight), 64'd1);
      fork
         begin
            for (int i = 9; i <= 16; i++) push(i, 2);
         end
         begin
            k = 0;
            while (!(sink_valid && sink_eop) && k < 300) begin
               @(negedge clk);
               k++;
            end
            chk("t5_eop_seen", 64'(k < 300), 64'd1);
            source_valid = 1'b1;
            source_eop   = 1'b1;
            @(negedge clk);
            source_valid = 1'b0;
            source_eop   = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      chk("t5_inflight_same", 64'(inflight), 64'd1);
      chk("t5_frames_sent", 64'(frames_sent), 64'd2);

      // Reset in the middle of a frame.
      do_reset();
      rmode = 0;
      burst(1, 8);
      k = 0;
      while (!(sink_valid && sink_real == 4) && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("t6_word4_seen", 64'(k < 50), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_valid", 64'(sink_valid), 64'd0);
      chk("t6_sop", 64'(sink_sop), 64'd0);
      chk("t6_eop", 64'(sink_eop), 64'd0);
      chk("t6_real", 64'(sink_real), 64'd0);
      chk("t6_inflight", 64'(inflight), 64'd0);
      chk("t6_fftpts", 64'(fftpts_in), 64'd8);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      seen.delete();
      seen_cyc.delete();
      repeat (20) @(negedge clk);
      chk("t6_no_restart", 64'(seen.size()), 64'd0);
      chk("t6_frames_sent", 64'(frames_sent), 64'd0);

      // Random traffic against the model.
      do_reset();
      rmode = 3;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         sample_valid = ($urandom % 3) == 0;
         sample_in    = $urandom;
         source_valid = ($urandom % 8) == 0;
         source_eop   = 1'($urandom % 2);
      end
      sample_valid = 1'b0;
      source_valid = 1'b0;
      source_eop   = 1'b0;
      rmode        = 0;
      repeat (40) @(negedge clk);
      src_pulse();
      src_pulse();
      repeat (60) @(negedge clk);
      chk("rnd_drained", 64'(m_nfull), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sits between the audio sample source and the FFT megafunction sink.
- Collects real-valued samples into a ping-pong frame buffer (two banks of FFT_PTS words).
- Streams each full bank to the FFT as one Avalon-ST packet with sop/eop, honouring sink_ready back-pressure.
- Tracks frames in flight via the FFT source side and flags sample overruns.

Parameters:
DATA_W, 32, sample and sink_real/sink_imag width
FFT_PTS, 1024, points per frame; power of two, 8..1024
ADDR_W, 10, log2(FFT_PTS)
MAX_INFLIGHT, 2, max frames sent to FFT whose source_eop has not yet been seen

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
sample_in  in  DATA_W  signed sample from audio path
sample_valid  in  1  one-cycle strobe; sample_in valid this cycle
sink_valid  out  1  to FFT sink
sink_ready  in  1  from FFT sink
sink_sop  out  1  first word of frame
sink_eop  out  1  last word of frame
sink_real  out  DATA_W  sample to FFT
sink_imag  out  DATA_W  constant 0
fftpts_in  out  11  constant FFT_PTS
inverse  out  1  constant 0 (forward FFT)
source_valid  in  1  from FFT source
source_eop  in  1  from FFT source
inflight  out  2  frames currently in flight
overrun  out  1  sticky; set when a sample is dropped
frames_sent  out  16  count of frames fully accepted by FFT, wraps at 65535->0

Behaviour:
- Reset (async assert, sync release): all outputs 0 except fftpts_in = FFT_PTS.
  - Both banks empty, wr_bank = 0, write pointer 0, FSM in IDLE.
- Write side:
  - On sample_valid, store sample at wr_ptr in wr_bank, then increment wr_ptr.
  - When wr_ptr wraps from FFT_PTS-1 to 0, mark wr_bank full and toggle wr_bank.
  - If sample_valid arrives while wr_bank is still full (not yet drained): drop the sample, set overrun, leave wr_ptr unchanged.
  - overrun clears only on reset.
- Read FSM: IDLE -> PRIME -> STREAM -> IDLE.
  - IDLE: if rd_bank is full and inflight < MAX_INFLIGHT, issue a read of address 0 and go to PRIME.
  - PRIME (1 cycle, RAM read latency): load sink_real and assert sink_valid, with sink_sop = 1. Go to STREAM.
  - STREAM, transfer cycle (sink_valid & sink_ready):
    - If this word is address FFT_PTS-1, deassert sink_valid next cycle, clear full on rd_bank, toggle rd_bank, increment frames_sent, go to IDLE.
    - Otherwise present the next word on the following cycle. Prefetch so back-to-back transfers sustain 1 word/cycle with sink_ready held high.
  - STREAM, sink_ready low: sink_valid, sink_real, sink_sop and sink_eop hold their values.
  - sink_sop is high only on word 0; sink_eop is high only on word FFT_PTS-1.
- Latency: first sink_valid appears 2 cycles after the cycle in which the FSM sees the bank full (bank marked full, IDLE detect, PRIME).
- inflight:
  - +1 on the sink_eop transfer; -1 on source_valid & source_eop.
  - Both in the same cycle: no change.
  - Saturates at 0 on a spurious source_eop.
- A bank becoming full while STREAM is active on the other bank is picked up at the next IDLE.
- A bank can never be written and read at the same time: the write side only targets a non-full bank, and the read side only reads a full bank.
- Reset mid-frame: the frame is abandoned, buffers are discarded, and no partial sop/eop is emitted after release.

Test Plan:
- FFT_PTS=8, sink_ready=1, 8 samples 1..8 one every 4 cycles -> one packet: sink_real 1..8 on consecutive cycles, sop on 1, eop on 8; frames_sent=1; inflight=1.
- Same stimulus, sink_ready toggled 1,0,0,1,... -> data order 1..8 preserved; outputs stable during ready=0; exactly one sop and one eop.
- 24 samples back-to-back with sink_ready=0 throughout -> banks fill after samples 1..16; samples 17..24 dropped; overrun=1; release ready -> frames carry 1..8 then 9..16.
- Two frames sent, no source_eop -> third full bank waits in IDLE (sink_valid=0); source_valid & source_eop pulse -> inflight 2->1 and third frame starts within 2 cycles.
- source_eop in the same cycle as a sink_eop transfer -> inflight unchanged.
- reset_n asserted at word 4 of a frame -> all outputs 0 immediately; after release with no new samples, sink_valid stays 0.
